// File: rtl/min_n_32_seq_pkg.sv
// Shared constants and types for the streaming arg-min reducer.
// Holds FSM state encoding, score width and default frame size.
package min_n_32_seq_pkg;

  localparam int SCORE_W = 32;
  localparam int OCR_N   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/min_n_32_seq_if.sv
// Score-in / result-out bundle for the arg-min reducer.
// master: producer+consumer side; slave: reducer side.
//   in_valid/in_ready/in_data : score stream
//   out_valid/out_ready/out_min/out_idx : result
//   busy : frame partially accumulated
interface min_n_32_seq_if
  import min_n_32_seq_pkg::*;
#(
  parameter int W  = SCORE_W,
  parameter int IW = $clog2(OCR_N)
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_min;
  logic [IW-1:0] out_idx;
  logic          busy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_min,
    input  out_idx,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_min,
    output out_idx,
    output busy
  );
endinterface

// File: rtl/min_n_32_seq_cmp_lt_32.sv
// Combinational unsigned less-than; lt_o=1 selects a_i.
// Ports: a_i, b_i (W-bit unsigned), lt_o (a_i < b_i).
module cmp_lt_32
  import min_n_32_seq_pkg::*;
#(
  parameter int W = SCORE_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o
);
  // Strict compare: equal scores keep the earlier one.
  assign lt_o = (a_i < b_i);
endmodule

// File: rtl/min_n_32_seq.sv
// Streaming arg-min: N scores in, min value + first index out.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module min_n_32_seq
  import min_n_32_seq_pkg::*;
#(
  parameter int N = OCR_N,
  parameter int W = SCORE_W
) (
  input logic            clk,
  input logic            rst,
  min_n_32_seq_if.slave  bus
);
  localparam int IW = $clog2(N);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  min_q,   min_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [W-1:0]  omin_q,  omin_d;
  logic [IW-1:0] oidx_q,  oidx_d;

  logic in_rdy;
  logic in_beat;
  logic lt;

  cmp_lt_32 #(
    .W (W)
  ) u_cmp (
    .a_i  (bus.in_data),
    .b_i  (min_q),
    .lt_o (lt)
  );

  // Low during the reset cycle itself.
  assign in_rdy  = ~rst & (state_q != ST_DONE);
  assign in_beat = bus.in_valid & in_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    idx_d   = idx_q;
    omin_d  = omin_q;
    oidx_d  = oidx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_beat) begin
          min_d   = bus.in_data;
          idx_d   = '0;
          cnt_d   = IW'(1);
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_beat) begin
          if (lt) begin
            min_d = bus.in_data;
            idx_d = cnt_q;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IW'(N - 1)) begin
            // Last beat: publish merged result directly.
            omin_d  = lt ? bus.in_data : min_q;
            oidx_d  = lt ? cnt_q : idx_q;
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      min_q   <= '0;
      idx_q   <= '0;
      omin_q  <= '0;
      oidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
      omin_q  <= omin_d;
      oidx_q  <= oidx_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_ACC);
  assign bus.out_min   = omin_q;
  assign bus.out_idx   = oidx_q;
endmodule

// File: doc/min_n_32_seq.md
Name: min_n_32_seq

Overview:
- Streaming arg-min reducer and the counterpart of the combinational 2-input max comparator.
- Consumes N unsigned 32-bit scores, one per handshake beat. After the Nth beat it presents the minimum value and the index of that value.
- Sits downstream of the OneByN distance/score stage in the OCR datapath. Used where the smallest distance wins, e.g. template-match error.
- Produces one result per N-score frame, handed off through a valid/ready output handshake.

Parameters:
- N, 10, scores per frame; legal range 2..1024.
- W, 32, score width in bits, unsigned.
- IW, $clog2(N), index width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid score.
- in_ready  output  1  block accepts a score this cycle.
- in_data  input  W  score, unsigned.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- out_min  output  W  minimum score of the frame.
- out_idx  output  IW  beat index (0..N-1) of the minimum.
- busy  output  1  a frame is partially accumulated.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: in_ready=0 for the reset cycle, then 1 in IDLE; out_valid=0, out_min=0, out_idx=0, busy=0. The internal beat counter and running min/idx registers are cleared.
- Input beat = in_valid & in_ready on a rising edge. Output beat = out_valid & out_ready.
- State IDLE: in_ready=1, busy=0.
  - On a beat: load min=in_data, idx=0, cnt=1; go to ACC.
- State ACC: in_ready=1, busy=1.
  - On a beat, if in_data < min (strict, unsigned): min<=in_data, idx<=cnt.
  - On a beat, cnt<=cnt+1.
  - When the beat is the one with cnt==N-1: go to DONE next cycle.
- State DONE: in_ready=0, out_valid=1, out_min/out_idx stable; busy=0.
  - On an output beat: go to IDLE; out_valid drops the following cycle.
  - No bypass: in_ready stays 0 in the accept cycle. Throughput is N+1 cycles per frame, plus any out_ready stall.
- Latency: out_valid asserts the cycle after the Nth input beat.
- Ties: on equal scores the earliest index is kept, the same first-wins policy as the max comparator on equality.
- Gaps: in_valid low in ACC simply pauses accumulation; the counter holds.
- out_ready low in DONE: result held indefinitely; no input accepted; no data lost.
- Values 0 and 32'hFFFF_FFFF are handled with full unsigned compare. No signed interpretation.
- rst asserted mid-frame or in DONE: state returns to IDLE next edge; the partial frame is discarded; out_valid=0.
- in_data, in_valid and out_ready are don't-care while rst=1.
- out_min/out_idx update only when entering DONE. Outside DONE they hold the last result, and are 0 after reset.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_ACC=2'd1, ST_DONE=2'd2;
  - score width constant SCORE_W=32;
  - default frame size constant OCR_N=10.
- One natural sub-module: cmp_lt_32, a combinational unsigned less-than that returns the select bit (the min-direction mirror of the existing max comparator). Instantiated once for the running compare.
- Counter, state register and output registers stay in the top module.

Test Plan:
- Reset then a frame of N=10 scores [50,40,60,40,70,10,90,10,30,20], out_ready=1 -> out_valid rises 1 cycle after the 10th beat; out_min=10, out_idx=5 (first of the tie); in_ready=0 during DONE.
- Scores descending 100..91 with in_valid toggling every other cycle -> out_min=91, out_idx=9; busy=1 throughout the gaps; no extra beats counted.
- Extremes [FFFFFFFF x9, 0 at index 0] and [0 x10] -> first frame gives out_min=0, out_idx=0; second gives out_min=0, out_idx=0 (tie keeps index 0).
- Hold out_ready=0 for 20 cycles in DONE while in_valid=1 -> out_min/out_idx stable, in_ready=0, no input consumed. Release -> next frame starts cleanly and its result is correct.
- Assert rst after 6 beats of a frame, then send a fresh full frame [7,3,9,3,...] -> partial frame discarded; out_min=3, out_idx=1; out_valid never pulses for the aborted frame.
- Back-to-back frames with out_ready=1 -> one result every N+1 cycles; idx resets to 0 each frame.
